dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge_pkg.sv | 18 +
 rtl/dmem_bridge_timer.sv | 39 +++
 rtl/dmem_bridge.sv | 137 +++++++++++++
 tb/tb_dmem_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg
//   Types and constants shared by the processor-to-bus data-memory bridge.
//   - state_e          : bridge FSM state, plain binary encoding
//   - TIMEOUT_DEFAULT  : default bus-wait cycles before a transaction aborts
//   - TIMER_W          : width of the timeout counter (covers 1..1023)
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned TIMER_W         = 10;

endpackage

// File: rtl/dmem_bridge_timer.sv
// bridge_timer
//   Bus-wait timeout counter for dmem_bridge.
//   Ports:
//     clk        : clock, rising edge
//     reset      : asynchronous active-low reset
//     clear_i    : restart the count from zero
//     enable_i   : count this cycle
//     expired_o  : this enabled cycle is the TIMEOUT_CYCLES-th one
module bridge_timer
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + TIMER_W'(1);
        end
    end

    // Flagged one cycle early so the FSM leaves exactly when the count
    // would reach TIMEOUT_CYCLES.
    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge
//   Bridges a stalling processor memory stage onto a valid/ready request bus
//   with a separate response strobe. One transaction outstanding at a time.
//   Ports:
//     clk, reset                 : clock, asynchronous active-low reset
//     p_addr/p_wdata/p_wmask     : processor address, store data, byte mask
//     p_wen/p_ren                : processor store / load request
//     p_rdata                    : load data, updated on completion, held otherwise
//     p_stall                    : processor must hold its request while high
//     b_valid/b_ready            : bus request handshake
//     b_addr/b_wdata/b_wstrb/b_write : latched bus request fields
//     b_rsp_valid/b_rdata        : bus response
//     bus_err                    : sticky timeout flag
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    input  logic [3:0]  p_wmask,
    input  logic        p_wen,
    input  logic        p_ren,
    output logic [31:0] p_rdata,
    output logic        p_stall,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [31:0] b_addr,
    output logic [31:0] b_wdata,
    output logic [3:0]  b_wstrb,
    output logic        b_write,
    input  logic        b_rsp_valid,
    input  logic [31:0] b_rdata,
    output logic        bus_err
);

    state_e      state_q;
    logic        b_valid_q;
    logic [31:0] b_addr_q;
    logic [31:0] b_wdata_q;
    logic [3:0]  b_wstrb_q;
    logic        b_write_q;
    logic [31:0] p_rdata_q;
    logic        bus_err_q;

    logic        wr_req_d;
    logic        request_d;
    logic        expired;
    logic        unused_addr_lsb;

    // A store with an empty mask is not a request; store wins over load.
    assign wr_req_d  = p_wen && (p_wmask != '0);
    assign request_d = wr_req_d || p_ren;

    assign unused_addr_lsb = ^p_addr[1:0];

    bridge_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  ((state_q == ST_IDLE) && request_d),
        .enable_i ((state_q == ST_REQ) || (state_q == ST_WAIT)),
        .expired_o(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            b_valid_q <= 1'b0;
            b_addr_q  <= '0;
            b_wdata_q <= '0;
            b_wstrb_q <= '0;
            b_write_q <= 1'b0;
            p_rdata_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (request_d) begin
                        b_addr_q  <= {p_addr[31:2], 2'b00};
                        b_wdata_q <= p_wdata;
                        b_wstrb_q <= wr_req_d ? p_wmask : '0;
                        b_write_q <= wr_req_d;
                        b_valid_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Timeout beats a same-cycle accept; any response strobe
                    // seen here is not for this request and is dropped.
                    if (expired) begin
                        b_valid_q <= 1'b0;
                        p_rdata_q <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (b_ready) begin
                        b_valid_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response arriving in the final counted cycle is honoured.
                    if (b_rsp_valid) begin
                        if (!b_write_q) begin
                            p_rdata_q <= b_rdata;
                        end
                        state_q <= ST_DONE;
                    end else if (expired) begin
                        p_rdata_q <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign p_stall = ((state_q == ST_IDLE) && request_d) ||
                     (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign p_rdata = p_rdata_q;
    assign b_valid = b_valid_q;
    assign b_addr  = b_addr_q;
    assign b_wdata = b_wdata_q;
    assign b_wstrb = b_wstrb_q;
    assign b_write = b_write_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge
//   Directed and randomized transactions against dmem_bridge with a
//   transaction-level expectation model (latency, data, sticky error).
module tb_dmem_bridge;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wmask;
    logic        p_wen;
    logic        p_ren;
    logic [31:0] p_rdata;
    logic        p_stall;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_wstrb;
    logic        b_write;
    logic        b_rsp_valid;
    logic [31:0] b_rdata;
    logic        bus_err;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .p_wmask    (p_wmask),
        .p_wen      (p_wen),
        .p_ren      (p_ren),
        .p_rdata    (p_rdata),
        .p_stall    (p_stall),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_wstrb    (b_wstrb),
        .b_write    (b_write),
        .b_rsp_valid(b_rsp_valid),
        .b_rdata    (b_rdata),
        .bus_err    (bus_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        p_wen       = 1'b0;
        p_ren       = 1'b0;
        p_wmask     = 4'h0;
        b_ready     = 1'b0;
        b_rsp_valid = 1'b0;
    endtask

    // One processor transaction. The bus accepts in stall cycle rdy_dly+1 and
    // responds rsp_dly+1 cycles after that. With noise set, stray b_rsp_valid
    // pulses appear while the request is pending and after completion, and
    // stray b_ready pulses appear while awaiting the response.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input logic wen, input logic ren,
                           input int unsigned rdy_dly, input int unsigned rsp_dly,
                           input logic [31:0] rsp_data, input bit noise);
        bit          wr;
        bit          req;
        bit          timeout;
        int unsigned n_req;
        int unsigned n_rsp;
        int unsigned busy;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;

        wr       = wen && (mask != 4'h0);
        req      = wr || ren;
        n_req    = rdy_dly + 1;
        n_rsp    = n_req + rsp_dly + 1;
        exp_addr = {addr[31:2], 2'b00};
        exp_strb = wr ? mask : 4'h0;
        if (n_req >= T) begin
            timeout = 1'b1;
            busy    = T;
        end else if (n_rsp <= T) begin
            timeout = 1'b0;
            busy    = n_rsp;
        end else begin
            timeout = 1'b1;
            busy    = T;
        end

        @(negedge clk);
        p_addr      = addr;
        p_wdata     = wdata;
        p_wmask     = mask;
        p_wen       = wen;
        p_ren       = ren;
        b_ready     = 1'b0;
        b_rsp_valid = 1'b0;
        #1;
        check("stall_c0", 32'(p_stall), 32'(req));

        if (!req) begin
            repeat (3) begin
                @(negedge clk);
                #1;
                check("noreq_bvalid", 32'(b_valid), 32'd0);
                check("noreq_stall", 32'(p_stall), 32'd0);
            end
            idle_inputs();
            return;
        end

        for (int unsigned i = 1; i <= busy; i++) begin
            @(negedge clk);
            b_ready     = (i == n_req);
            b_rsp_valid = (i == n_rsp);
            b_rdata     = (i == n_rsp) ? rsp_data : $urandom;
            if (noise && i <= n_req) b_rsp_valid = 1'($urandom_range(0, 1));
            if (noise && i > n_req)  b_ready = 1'($urandom_range(0, 1));
            #1;
            check("busy_stall", 32'(p_stall), 32'd1);
            check("busy_bvalid", 32'(b_valid), 32'(i <= n_req));
            check("busy_rdata_hold", p_rdata, exp_rdata);
            if (i <= n_req) begin
                check("b_addr", b_addr, exp_addr);
                check("b_wstrb", 32'(b_wstrb), 32'(exp_strb));
                check("b_write", 32'(b_write), 32'(wr));
                if (wr) check("b_wdata", b_wdata, wdata);
            end
        end

        if (timeout) begin
            exp_rdata = 32'h0;
            exp_err   = 1'b1;
        end else if (!wr) begin
            exp_rdata = rsp_data;
        end

        @(negedge clk);
        p_wen       = 1'b0;
        p_ren       = 1'b0;
        b_ready     = 1'b0;
        b_rsp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        b_rdata     = $urandom;
        #1;
        check("done_stall", 32'(p_stall), 32'd0);
        check("done_bvalid", 32'(b_valid), 32'd0);
        check("done_rdata", p_rdata, exp_rdata);
        check("done_bus_err", 32'(bus_err), 32'(exp_err));

        @(negedge clk);
        b_rsp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        b_rdata     = $urandom;
        #1;
        check("idle_rdata_hold", p_rdata, exp_rdata);
        check("idle_stall", 32'(p_stall), 32'd0);
        idle_inputs();
    endtask

    initial begin
        reset     = 1'b0;
        p_addr    = 32'h0;
        p_wdata   = 32'h0;
        b_rdata   = 32'h0;
        idle_inputs();
        exp_rdata = 32'h0;
        exp_err   = 1'b0;

        @(negedge clk);
        #1;
        check("rst_rdata", p_rdata, 32'h0);
        check("rst_bvalid", 32'(b_valid), 32'd0);
        check("rst_stall", 32'(p_stall), 32'd0);
        check("rst_baddr", b_addr, 32'h0);
        check("rst_bwdata", b_wdata, 32'h0);
        check("rst_bwstrb", 32'(b_wstrb), 32'd0);
        check("rst_bwrite", 32'(b_write), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Best-case read.
        run_txn(32'h0000_1004, 32'h0, 4'h0, 1'b0, 1'b1, 0, 0, 32'hDEAD_BEEF, 1'b0);
        // Write with a slow accept: fields must stay put while waiting.
        run_txn(32'h0000_2002, 32'h1122_3344, 4'b1100, 1'b1, 1'b0, 4, 0, 32'h5555_AAAA, 1'b0);
        // Empty-mask store: no request at all.
        run_txn(32'h0000_3000, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 0, 0, 32'h0, 1'b0);
        // Store and load together behave as a store.
        run_txn(32'h0000_4007, 32'hCAFE_F00D, 4'b0011, 1'b1, 1'b1, 1, 2, 32'h7777_7777, 1'b1);
        // Response arriving in the last counted cycle still completes normally.
        run_txn(32'h0000_5000, 32'h0, 4'h0, 1'b0, 1'b1, 2, T - 4, 32'h1357_9BDF, 1'b0);
        // Bus never responds, then never accepts; error stays sticky over a good read.
        run_txn(32'h0000_6000, 32'h0, 4'h0, 1'b0, 1'b1, 0, 1000, 32'h0, 1'b0);
        run_txn(32'h0000_6100, 32'h1, 4'hF, 1'b1, 1'b0, 1000, 0, 32'h0, 1'b0);
        run_txn(32'h0000_7000, 32'h0, 4'h0, 1'b0, 1'b1, 0, 0, 32'h2468_ACE0, 1'b0);

        // Reset while awaiting the response, then a late response strobe.
        @(negedge clk);
        p_addr = 32'h0000_8000;
        p_ren  = 1'b1;
        @(negedge clk);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        #1;
        check("rstw_stall_before", 32'(p_stall), 32'd1);
        reset = 1'b0;
        p_ren = 1'b0;
        #1;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        check("rstw_stall", 32'(p_stall), 32'd0);
        check("rstw_bvalid", 32'(b_valid), 32'd0);
        check("rstw_rdata", p_rdata, exp_rdata);
        check("rstw_bus_err", 32'(bus_err), 32'(exp_err));
        check("rstw_baddr", b_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        b_rsp_valid = 1'b1;
        b_rdata     = 32'hBAD0_BAD0;
        #1;
        check("late_rsp_bvalid", 32'(b_valid), 32'd0);
        @(negedge clk);
        b_rsp_valid = 1'b0;
        #1;
        check("late_rsp_rdata", p_rdata, 32'h0);
        check("late_rsp_stall", 32'(p_stall), 32'd0);
        check("late_rsp_bvalid2", 32'(b_valid), 32'd0);

        // Randomized traffic; some of these time out.
        for (int n = 0; n < 60; n++) begin
            run_txn($urandom, $urandom, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 4), $urandom, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
